ntt_job_sched: RTL
==================

# ntt_job_sched

Round-robin scheduler that shares one `ntt` compute instance (64-point, 8-bit twiddles) among `NREQ` requesters. It grants one requester at a time and drives the `ntt` synchronous start/reset input. It tracks completion through the `ntt` sticky `done`, then returns a one-cycle completion pulse to the winner. Data steering (`x`, `w` in; `y` out) is done by external muxes driven from `sel`. This block carries control only.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 128: max cycles in WAIT before a job is aborted. Must be greater than 72.

Ports:
- `clk`, input, 1: sole clock.
- `rst`, input, 1: asynchronous, active-low reset.
- `req`, input, NREQ: level request per requester. Held until that requester's `job_done`.
- `gnt`, output, NREQ: one-hot grant. Stable from grant until the completion pulse.
- `sel`, output, $clog2(NREQ): binary index of the granted requester. Drives the external x/w/y muxes.
- `ntt_start`, output, 1: connects to the `ntt` `rst` pin. One-cycle high pulse per job.
- `ntt_done`, input, 1: from `ntt` `done`. Sticky high until the next `ntt_start` is sampled.
- `job_done`, output, NREQ: one-cycle pulse to the granted requester. `y` is valid on the external mux in this cycle.
- `job_err`, output, 1: one-cycle pulse coincident with `job_done` when the job timed out.
- `busy`, output, 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, START, WAIT, DONE.
- **IDLE**: if any `req` bit is high, pick the winner by round-robin and go to START. Otherwise stay.
  - Search order is `last+1, last+2, …` modulo NREQ. `last` resets to NREQ-1, so index 0 wins first after reset.
- **START** (exactly 1 cycle):
  - `ntt_start`=1.
  - `gnt` and `sel` are registered on entry and held.
  - Next state is WAIT.
- **WAIT**:
  - `ntt_start`=0.
  - Timeout counter starts at 0 and increments each cycle.
  - `ntt_done` is ignored in the first WAIT cycle, which guards against a stale sticky `done` from the previous job.
  - From the second cycle on, `ntt_done`=1 moves to DONE with `err`=0.
  - If the counter reaches TIMEOUT-1 without `ntt_done`, move to DONE with `err`=1.
- **DONE** (exactly 1 cycle):
  - `job_done[sel]`=1 and `job_err`=`err`.
  - `last` takes the value of `sel`.
  - Next state is IDLE; `gnt` clears on that transition.
- `req` deassertion by the granted requester during START/WAIT is ignored. The job completes and `job_done` still pulses.
- `req` changes from non-granted requesters have no effect until IDLE.
- A requester that keeps `req` high after its `job_done` is treated as a new request. Round-robin guarantees other pending requesters are served first.
- `req` all-zero in IDLE: stay idle, all outputs low.

## Timing
- Reset, asynchronous and active-low: state=IDLE, `gnt`=0, `sel`=0, `ntt_start`=0, `job_done`=0, `job_err`=0, `busy`=0, counter=0, `last`=NREQ-1.
- Reset asserted mid-job aborts immediately with no `job_done`. The partly run `ntt` is recovered by the next `ntt_start`.
- All outputs are registered.
- `req` sampled high in IDLE at edge E0 gives `gnt`/`sel`/`ntt_start`/`busy` high after E0.
- `ntt` samples `ntt_start` at E1: `done` clears and its count starts. `ntt_start` drops after E1.
- `ntt` asserts `done` 72 edges after sampling its reset, at E73.
  - The scheduler sees `ntt_done` high after E73.
  - It enters DONE at E74, with `job_done` high between E74 and E75.
  - Back in IDLE after E75.
- Nominal request-to-`job_done` latency is 74 cycles.
- The next grant can be issued at E76, so back-to-back jobs occupy 76 cycles per job.
- Timeout path: `job_done`/`job_err` pulse TIMEOUT+1 cycles after `ntt_start` rises.
- `gnt` never has more than one bit set. `gnt` is nonzero only while `busy`=1.

## Test plan
- Single request, NREQ=4, `req`=0001 with the `ntt` model attached:
  - `ntt_start` is high for exactly one cycle.
  - `gnt`=0001 and `sel`=0 are held.
  - `job_done`=0001 pulses 74 cycles after `req` is sampled, with `job_err`=0.
- All requesters held, `req`=1111:
  - Grant order is 0,1,2,3,0,… with each `job_done` spaced 76 cycles apart.
  - `gnt` is always one-hot or zero.
- Stale done: hold `ntt_done`=1 from the previous job through START and the first WAIT cycle, then drop it.
  - No premature DONE.
  - Completion occurs only on the next real rise of `ntt_done`.
- Timeout: `ntt_done` stuck at 0 with TIMEOUT=128.
  - `job_done` and `job_err` pulse together 129 cycles after `ntt_start`.
  - The next requester is then granted normally.
- Requester drop: `req`=0100 granted, then `req` goes to 0000 at cycle 10.
  - The job still completes.
  - `job_done`=0100 pulses.
  - The block returns to IDLE with `busy`=0.
- Async reset at cycle 30 of WAIT:
  - All outputs go low immediately, with no `job_done`.
  - After release with `req`=0010, requester 1 is granted and completes normally.

Source files
------------

// File: rtl/ntt_job_sched.sv
// Round-robin control scheduler sharing one 64-point ntt engine among NREQ requesters.
// Grants one requester at a time, pulses the ntt start/reset input, waits for the
// sticky ntt done (or a timeout), then returns a one-cycle completion pulse.
module ntt_job_sched #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 128
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] sel,
  output logic                    ntt_start,
  input  logic                    ntt_done,
  output logic [NREQ-1:0]         job_done,
  output logic                    job_err,
  output logic                    busy
);

  localparam int SW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);
  localparam logic [SW-1:0] LAST_RST = SW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

  state_t          state, state_n;
  logic [NREQ-1:0] gnt_n, job_done_n;
  logic [SW-1:0]   sel_n, last, last_n, win;
  logic [CW-1:0]   cnt, cnt_n;
  logic            start_n, job_err_n, busy_n;

  // Round-robin pick: scan last+1, last+2, ... so the previous winner has lowest priority.
  always_comb begin
    win = last;
    // Descending scan: the smallest offset with a pending request is written last and wins.
    for (int i = NREQ; i >= 1; i--) begin
      if (req[SW'((int'(last) + i) % NREQ)]) win = SW'((int'(last) + i) % NREQ);
    end
  end

  // Next-state and next-output logic for the job FSM.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_n    = state;
    gnt_n      = gnt;
    sel_n      = sel;
    last_n     = last;
    cnt_n      = cnt;
    start_n    = 1'b0;
    job_done_n = '0;
    job_err_n  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (|req) begin
          state_n    = S_START;
          gnt_n      = '0;
          gnt_n[win] = 1'b1;
          sel_n      = win;
          start_n    = 1'b1;
        end
      end
      S_START: begin
        state_n = S_WAIT;
        cnt_n   = '0;
      end
      S_WAIT: begin
        cnt_n = cnt + 1'b1;
        // The first WAIT cycle may still see the previous job's sticky done; skip it.
        if ((cnt != '0) && ntt_done) begin
          state_n    = S_DONE;
          job_done_n = gnt;
        end else if (cnt == CNT_MAX) begin
          state_n    = S_DONE;
          job_done_n = gnt;
          job_err_n  = 1'b1;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        gnt_n   = '0;
        sel_n   = '0;
        last_n  = sel;
      end
      default: state_n = S_IDLE;
    endcase
    busy_n = (state_n != S_IDLE);
  end

  // State and registered outputs; asynchronous active-low reset aborts any job.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      gnt       <= '0;
      sel       <= '0;
      last      <= LAST_RST;
      cnt       <= '0;
      ntt_start <= 1'b0;
      job_done  <= '0;
      job_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
      state     <= state_n;
      gnt       <= gnt_n;
      sel       <= sel_n;
      last      <= last_n;
      cnt       <= cnt_n;
      ntt_start <= start_n;
      job_done  <= job_done_n;
      job_err   <= job_err_n;
      busy      <= busy_n;
    end
  end

endmodule
